// File: rtl/kugelblitz_rewrite_ctrl_pkg.sv
// ============================================================================
// Module   : kugelblitz_rewrite_ctrl_pkg
// Purpose  : Shared definitions for the kugelblitz rewrite controller:
//            stream width, FSM state encodings, rule-entry field layout and
//            pack/unpack helpers for the rule table words.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package kugelblitz_rewrite_ctrl_pkg;

    // The rewrite datapath only exists at 512 bits.
    localparam int KG_DATA_WIDTH = 512;
    localparam int KG_LANE_W     = $clog2(KG_DATA_WIDTH / 8);
    localparam int KG_VALUE_W    = 8;
    localparam int KG_MAX_RULES  = 16;

    // Rule entry layout inside a table word: {enable, lane, value}.
    localparam int KG_RULE_VALUE_LSB = 0;
    localparam int KG_RULE_LANE_LSB  = KG_RULE_VALUE_LSB + KG_VALUE_W;
    localparam int KG_RULE_EN_BIT    = KG_RULE_LANE_LSB + KG_LANE_W;
    localparam int KG_RULE_W         = KG_RULE_EN_BIT + 1;

    // Controller state encodings.
    localparam logic [1:0] KG_ST_IDLE    = 2'd0;
    localparam logic [1:0] KG_ST_COMPILE = 2'd1;
    localparam logic [1:0] KG_ST_WAIT    = 2'd2;

    typedef struct packed {
        logic                  en;
        logic [KG_LANE_W-1:0]  lane;
        logic [KG_VALUE_W-1:0] value;
    } kg_rule_t;

    function automatic logic [KG_RULE_W-1:0] kg_pack_rule(
        input logic                  en,
        input logic [KG_LANE_W-1:0]  lane,
        input logic [KG_VALUE_W-1:0] value
    );
        logic [KG_RULE_W-1:0] word;
        word                                          = '0;
        word[KG_RULE_VALUE_LSB +: KG_VALUE_W]         = value;
        word[KG_RULE_LANE_LSB  +: KG_LANE_W]          = lane;
        word[KG_RULE_EN_BIT]                          = en;
        return word;
    endfunction

    function automatic kg_rule_t kg_unpack_rule(input logic [KG_RULE_W-1:0] word);
        kg_rule_t r;
        r.value = word[KG_RULE_VALUE_LSB +: KG_VALUE_W];
        r.lane  = word[KG_RULE_LANE_LSB  +: KG_LANE_W];
        r.en    = word[KG_RULE_EN_BIT];
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/kugelblitz_rule_table.sv
// ============================================================================
// Module   : kugelblitz_rule_table
// Purpose  : Rule storage for the rewrite controller. One synchronous write
//            port, one combinational index read port, asynchronous
//            active-low clear of every entry.
// Ports    : clk, rst_n            clock / async active-low clear
//            wr_en_i, wr_idx_i,
//            wr_word_i             write port (packed rule word)
//            rd_idx_i, rd_word_o   read port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kugelblitz_rule_table
    import kugelblitz_rewrite_ctrl_pkg::*;
#(
    parameter int NUM_RULES = 8,
    parameter int IDX_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en_i,
    input  logic [IDX_W-1:0]     wr_idx_i,
    input  logic [KG_RULE_W-1:0] wr_word_i,
    input  logic [IDX_W-1:0]     rd_idx_i,
    output logic [KG_RULE_W-1:0] rd_word_o
);

    logic [KG_RULE_W-1:0] entry_q [NUM_RULES];

    // Indices beyond the table depth (non power-of-two depths) are ignored
    // on write and read back as a disabled rule.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                entry_q[i] <= '0;
            end
        end else if (wr_en_i && (int'(wr_idx_i) < NUM_RULES)) begin
            entry_q[wr_idx_i] <= wr_word_i;
        end
    end

    always_comb begin
        rd_word_o = '0;
        if (int'(rd_idx_i) < NUM_RULES) begin
            rd_word_o = entry_q[rd_idx_i];
        end
    end

endmodule

`default_nettype wire

// File: rtl/kugelblitz_rewrite_ctrl.sv
// ============================================================================
// Module   : kugelblitz_rewrite_ctrl
// Purpose  : Rule-set controller for the kugelblitz byte-rewrite datapath.
//            Software writes rules, then commits; the rules are compiled one
//            per cycle into a shadow mask/data bank, which is swapped into
//            the active outputs only at a frame boundary of the monitored
//            stream so every frame sees one coherent rule set.
// Ports    : clk, rst_n                       clock / async active-low reset
//            cfg_wr_*_i, cfg_wr_ready_o       rule write channel
//            commit_valid_i, commit_ready_o   commit request
//            commit_done_o                    pulse when new set is active
//            busy_o                           compile or wait in progress
//            mon_tvalid/tready/tlast_i        monitored stream handshake
//            ovr_mask_o, ovr_data_o           active per-lane overwrite set
//            active_gen_o                     completed-commit counter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module kugelblitz_rewrite_ctrl
    import kugelblitz_rewrite_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = 512,
    parameter  int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter  int NUM_RULES  = 8,
    parameter  int GEN_WIDTH  = 8,
    localparam int IDX_W      = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1,
    localparam int LANE_W     = $clog2(KEEP_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_wr_valid_i,
    output logic                  cfg_wr_ready_o,
    input  logic [IDX_W-1:0]      cfg_wr_index_i,
    input  logic [LANE_W-1:0]     cfg_wr_lane_i,
    input  logic [7:0]            cfg_wr_value_i,
    input  logic                  cfg_wr_enable_i,
    input  logic                  commit_valid_i,
    output logic                  commit_ready_o,
    output logic                  commit_done_o,
    output logic                  busy_o,
    input  logic                  mon_tvalid_i,
    input  logic                  mon_tready_i,
    input  logic                  mon_tlast_i,
    output logic [KEEP_WIDTH-1:0] ovr_mask_o,
    output logic [DATA_WIDTH-1:0] ovr_data_o,
    output logic [GEN_WIDTH-1:0]  active_gen_o
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (DATA_WIDTH != KG_DATA_WIDTH) begin : g_bad_data_width
            $error("kugelblitz_rewrite_ctrl: DATA_WIDTH must be 512");
        end
        if (KEEP_WIDTH != DATA_WIDTH / 8) begin : g_bad_keep_width
            $error("kugelblitz_rewrite_ctrl: KEEP_WIDTH must be DATA_WIDTH/8");
        end
        if ((NUM_RULES < 1) || (NUM_RULES > KG_MAX_RULES)) begin : g_bad_num_rules
            $error("kugelblitz_rewrite_ctrl: NUM_RULES must be 1..16");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            state_q,       state_d;
    logic                  idle_q,        idle_d;
    logic [IDX_W-1:0]      idx_q,         idx_d;
    logic                  in_frame_q,    in_frame_d;
    logic [KEEP_WIDTH-1:0] shadow_mask_q, shadow_mask_d;
    logic [DATA_WIDTH-1:0] shadow_data_q, shadow_data_d;
    logic [KEEP_WIDTH-1:0] active_mask_q, active_mask_d;
    logic [DATA_WIDTH-1:0] active_data_q, active_data_d;
    logic [GEN_WIDTH-1:0]  gen_q,         gen_d;
    logic                  done_q,        done_d;

    logic                  w_beat;
    logic                  w_boundary;
    logic                  w_wr_fire;
    logic                  w_commit_fire;
    logic                  w_last_idx;
    logic [KG_RULE_W-1:0]  w_wr_word;
    logic [KG_RULE_W-1:0]  w_rd_word;
    kg_rule_t              w_rule;

    assign w_beat        = mon_tvalid_i & mon_tready_i;
    // Swap either in an idle gap outside a frame or on the closing beat of a
    // frame; the latter keeps back-to-back traffic from starving a commit.
    assign w_boundary    = (~in_frame_q & ~w_beat) | (w_beat & mon_tlast_i);
    assign w_wr_fire     = cfg_wr_valid_i & idle_q;
    assign w_commit_fire = commit_valid_i & idle_q;
    assign w_last_idx    = (idx_q == IDX_W'(NUM_RULES - 1));
    assign w_wr_word     = kg_pack_rule(cfg_wr_enable_i, cfg_wr_lane_i, cfg_wr_value_i);
    assign w_rule        = kg_unpack_rule(w_rd_word);

    // ------------------------------------------------------------------
    // Rule table: a write accepted together with a commit lands at the
    // same edge the FSM enters COMPILE, so entry 0 is read after it.
    // ------------------------------------------------------------------
    kugelblitz_rule_table #(
        .NUM_RULES (NUM_RULES),
        .IDX_W     (IDX_W)
    ) u_rule_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (w_wr_fire),
        .wr_idx_i  (cfg_wr_index_i),
        .wr_word_i (w_wr_word),
        .rd_idx_i  (idx_q),
        .rd_word_o (w_rd_word)
    );

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_mask_d = shadow_mask_q;
        shadow_data_d = shadow_data_q;
        active_mask_d = active_mask_q;
        active_data_d = active_data_q;
        gen_d         = gen_q;
        done_d        = 1'b0;

        in_frame_d = in_frame_q;
        if (w_beat) begin
            in_frame_d = ~mon_tlast_i;
        end

        case (state_q)
            KG_ST_IDLE: begin
                if (w_commit_fire) begin
                    shadow_mask_d = '0;
                    shadow_data_d = '0;
                    idx_d         = '0;
                    state_d       = KG_ST_COMPILE;
                end
            end
            KG_ST_COMPILE: begin
                // Entries are visited in ascending order, so a later rule on
                // the same lane overwrites an earlier one.
                if (w_rule.en) begin
                    shadow_mask_d[w_rule.lane]                  = 1'b1;
                    shadow_data_d[{w_rule.lane, 3'b000} +: 8]   = w_rule.value;
                end
                if (w_last_idx) begin
                    state_d = KG_ST_WAIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            KG_ST_WAIT: begin
                if (w_boundary) begin
                    active_mask_d = shadow_mask_q;
                    active_data_d = shadow_data_q;
                    gen_d         = gen_q + GEN_WIDTH'(1);
                    done_d        = 1'b1;
                    state_d       = KG_ST_IDLE;
                end
            end
            default: begin
                state_d = KG_ST_IDLE;
            end
        endcase

        idle_d = (state_d == KG_ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= KG_ST_IDLE;
            idle_q        <= 1'b1;
            idx_q         <= '0;
            in_frame_q    <= 1'b0;
            shadow_mask_q <= '0;
            shadow_data_q <= '0;
            active_mask_q <= '0;
            active_data_q <= '0;
            gen_q         <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idle_q        <= idle_d;
            idx_q         <= idx_d;
            in_frame_q    <= in_frame_d;
            shadow_mask_q <= shadow_mask_d;
            shadow_data_q <= shadow_data_d;
            active_mask_q <= active_mask_d;
            active_data_q <= active_data_d;
            gen_q         <= gen_d;
            done_q        <= done_d;
        end
    end

    // Every output comes straight from a flop.
    assign cfg_wr_ready_o = idle_q;
    assign commit_ready_o = idle_q;
    assign busy_o         = ~idle_q;
    assign commit_done_o  = done_q;
    assign ovr_mask_o     = active_mask_q;
    assign ovr_data_o     = active_data_q;
    assign active_gen_o   = gen_q;

endmodule

`default_nettype wire

// File: tb/tb_kugelblitz_rewrite_ctrl.sv
// ============================================================================
// Module   : tb_kugelblitz_rewrite_ctrl
// Purpose  : Self-checking bench for kugelblitz_rewrite_ctrl: directed rule
//            tables, multi-cycle corner sequences and random traffic checked
//            cycle by cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_kugelblitz_rewrite_ctrl;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int NR = 8;
    localparam int GW = 8;
    localparam int IW = 3;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_wr_valid = 1'b0;
    logic [IW-1:0] cfg_wr_index = '0;
    logic [LW-1:0] cfg_wr_lane = '0;
    logic [7:0]    cfg_wr_value = '0;
    logic          cfg_wr_enable = 1'b0;
    logic          commit_valid = 1'b0;
    logic          mon_tvalid = 1'b0;
    logic          mon_tready = 1'b0;
    logic          mon_tlast = 1'b0;
    logic          cfg_wr_ready, commit_ready, commit_done, busy;
    logic [KW-1:0] ovr_mask;
    logic [DW-1:0] ovr_data;
    logic [GW-1:0] active_gen;

    kugelblitz_rewrite_ctrl #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .NUM_RULES  (NR),
        .GEN_WIDTH  (GW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_wr_valid_i (cfg_wr_valid),
        .cfg_wr_ready_o (cfg_wr_ready),
        .cfg_wr_index_i (cfg_wr_index),
        .cfg_wr_lane_i  (cfg_wr_lane),
        .cfg_wr_value_i (cfg_wr_value),
        .cfg_wr_enable_i(cfg_wr_enable),
        .commit_valid_i (commit_valid),
        .commit_ready_o (commit_ready),
        .commit_done_o  (commit_done),
        .busy_o         (busy),
        .mon_tvalid_i   (mon_tvalid),
        .mon_tready_i   (mon_tready),
        .mon_tlast_i    (mon_tlast),
        .ovr_mask_o     (ovr_mask),
        .ovr_data_o     (ovr_data),
        .active_gen_o   (active_gen)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    bit          m_en   [NR];
    logic [5:0]  m_lane [NR];
    logic [7:0]  m_val  [NR];
    bit          m_busy;       // a commit is outstanding
    int          m_cnt;        // compile cycles still to go
    bit          m_inframe;
    logic [63:0] m_mask, p_mask;
    logic [511:0] m_data, p_data;
    logic [7:0]  m_gen;
    bit          m_done;
    bit          prev_tlast_beat;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_en[i] = 0; m_lane[i] = '0; m_val[i] = '0;
        end
        m_busy = 0; m_cnt = 0; m_inframe = 0;
        m_mask = '0; m_data = '0; p_mask = '0; p_data = '0;
        m_gen = '0; m_done = 0;
    endtask

    // Advance the model across one rising edge using the inputs now driven.
    task automatic model_step();
        bit beat;
        beat = mon_tvalid && mon_tready;
        prev_tlast_beat = beat && mon_tlast;
        m_done = 0;
        if (!m_busy) begin
            if (cfg_wr_valid) begin
                m_en[cfg_wr_index]   = cfg_wr_enable;
                m_lane[cfg_wr_index] = cfg_wr_lane;
                m_val[cfg_wr_index]  = cfg_wr_value;
            end
            if (commit_valid) begin
                // The whole rule set is resolved at once: last enabled rule
                // per lane wins.
                p_mask = '0; p_data = '0;
                for (int i = 0; i < NR; i++) begin
                    if (m_en[i]) begin
                        p_mask[m_lane[i]] = 1'b1;
                        p_data[m_lane[i]*8 +: 8] = m_val[i];
                    end
                end
                m_busy = 1;
                m_cnt  = NR;
            end
        end else if (m_cnt > 0) begin
            m_cnt--;
        end else if ((!m_inframe && !beat) || (beat && mon_tlast)) begin
            m_mask = p_mask;
            m_data = p_data;
            m_gen  = m_gen + 8'd1;
            m_done = 1;
            m_busy = 0;
        end
        if (beat) m_inframe = !mon_tlast;
    endtask

    task automatic compare_all();
        chk("ovr_mask",     ovr_mask,     m_mask);
        chk("ovr_data",     ovr_data,     m_data);
        chk("active_gen",   active_gen,   m_gen);
        chk("commit_done",  commit_done,  m_done);
        chk("busy",         busy,         m_busy);
        chk("cfg_wr_ready", cfg_wr_ready, !m_busy);
        chk("commit_ready", commit_ready, !m_busy);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic write_rule(input int idx, input bit en, input int lane, input int val);
        cfg_wr_valid  = 1'b1;
        cfg_wr_index  = IW'(idx);
        cfg_wr_enable = en;
        cfg_wr_lane   = LW'(lane);
        cfg_wr_value  = 8'(val);
        tick();
        cfg_wr_valid  = 1'b0;
    endtask

    task automatic commit_and_wait(input string name, input int budget);
        int k;
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        k = 0;
        while (!m_done && k < budget) begin
            tick();
            k++;
        end
        chk(name, commit_done, 1'b1);
    endtask

    // ---------------- directed rule-set table ----------------
    typedef struct {
        int ia; bit ea; int la; int va;
        int ib; bit eb; int lb; int vb;
        int probe;
        logic [63:0] exp_mask;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] sh;
        int k, bc;
        bit seen, acc_done;

        tbl[0] = '{0, 1, 5,  'hAA, 1, 0, 9,  'h33, 5,  64'h20,                8'hAA};
        tbl[1] = '{2, 1, 10, 'h11, 6, 1, 10, 'h22, 10, 64'h400,               8'h22};
        tbl[2] = '{6, 1, 10, 'h22, 2, 1, 10, 'h11, 10, 64'h400,               8'h22};
        tbl[3] = '{0, 1, 63, 'h5A, 7, 1, 0,  'hC3, 63, 64'h8000000000000001,  8'h5A};
        tbl[4] = '{3, 0, 4,  'h77, 4, 1, 4,  'h88, 4,  64'h10,                8'h88};
        tbl[5] = '{1, 0, 7,  'h12, 5, 0, 7,  'h34, 7,  64'h0,                 8'h00};

        // ---- reset state ----
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // ---- table-driven rule sets on an idle stream ----
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NR; i++) write_rule(i, 1'b0, 0, 0);
            write_rule(tbl[r].ia, tbl[r].ea, tbl[r].la, tbl[r].va);
            write_rule(tbl[r].ib, tbl[r].eb, tbl[r].lb, tbl[r].vb);
            commit_and_wait("tbl_done", NR + 6);
            sh = ovr_data >> (8 * tbl[r].probe);
            chk("tbl_mask", ovr_mask, tbl[r].exp_mask);
            chk("tbl_byte", sh[7:0], tbl[r].exp_byte);
            chk("tbl_gen", active_gen, 8'(r + 1));
        end

        // ---- exact latency, write and commit in the same cycle ----
        cfg_wr_valid = 1'b1; cfg_wr_index = 3'd0; cfg_wr_enable = 1'b1;
        cfg_wr_lane = 6'd5; cfg_wr_value = 8'hAA; commit_valid = 1'b1;
        tick();
        cfg_wr_valid = 1'b0; commit_valid = 1'b0;
        k = 0;
        while (!commit_done && k < 20) begin
            tick();
            k++;
        end
        chk("latency_cycles", k, NR + 1);
        chk("latency_mask", ovr_mask, 64'h20);
        chk("latency_byte", ovr_data[47:40], 8'hAA);

        // ---- commit in the middle of a frame ----
        write_rule(1, 1'b1, 9, 'h3C);
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0;
        tick();                                   // beat 0
        commit_valid = 1'b1;
        tick();                                   // beat 1, commit accepted
        commit_valid = 1'b0;
        mon_tready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("midframe_hold", ovr_mask, 64'h20);
        end
        mon_tready = 1'b1;
        for (int i = 2; i < 5; i++) begin
            tick();
            chk("midframe_hold", ovr_mask, 64'h20);
        end
        mon_tlast = 1'b1;
        tick();                                   // beat 5 (tlast)
        chk("midframe_swap_mask", ovr_mask, 64'h220);
        chk("midframe_swap_done", commit_done, 1'b1);
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        tick();

        // ---- back-to-back 3-beat frames ----
        write_rule(3, 1'b1, 63, 'h99);
        mon_tvalid = 1'b1; mon_tready = 1'b1;
        bc = 0; seen = 0;
        commit_valid = 1'b1;
        for (int i = 0; i < 80 && !seen; i++) begin
            mon_tlast = (bc % 3 == 2);
            tick();
            commit_valid = 1'b0;
            bc++;
            if (commit_done) begin
                chk("b2b_after_tlast", prev_tlast_beat, 1'b1);
                seen = 1;
            end
        end
        chk("b2b_done_seen", seen, 1'b1);
        chk("b2b_mask", ovr_mask, 64'h8000000000000220);
        while (bc % 3 != 0) begin
            mon_tlast = (bc % 3 == 2);
            tick();
            bc++;
        end
        mon_tvalid = 1'b0; mon_tlast = 1'b0;

        // ---- handshake: write held through COMPILE/WAIT ----
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        cfg_wr_valid = 1'b1; cfg_wr_index = 3'd4; cfg_wr_enable = 1'b1;
        cfg_wr_lane = 6'd20; cfg_wr_value = 8'h55;
        acc_done = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (cfg_wr_ready) begin
                seen = 1;
                acc_done = commit_done;
            end
            tick();
        end
        cfg_wr_valid = 1'b0;
        chk("hs_accepted", seen, 1'b1);
        chk("hs_first_idle", acc_done, 1'b1);
        repeat (3) tick();
        chk("hs_no_effect", ovr_mask[20], 1'b0);
        commit_and_wait("hs_done", NR + 6);
        chk("hs_next_commit", ovr_mask[20], 1'b1);
        chk("hs_byte", ovr_data[167:160], 8'h55);

        // ---- random traffic against the model ----
        for (int i = 0; i < 1500; i++) begin
            cfg_wr_valid  = ($urandom_range(99) < 20);
            cfg_wr_index  = IW'($urandom_range(NR - 1));
            cfg_wr_enable = ($urandom_range(99) < 70);
            cfg_wr_lane   = LW'($urandom_range(63));
            cfg_wr_value  = 8'($urandom_range(255));
            commit_valid  = ($urandom_range(99) < 6);
            mon_tvalid    = ($urandom_range(99) < 60);
            mon_tready    = ($urandom_range(99) < 70);
            mon_tlast     = ($urandom_range(99) < 25);
            tick();
        end
        cfg_wr_valid = 1'b0; commit_valid = 1'b0;
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b1;
        tick();
        mon_tvalid = 1'b0; mon_tlast = 1'b0;
        k = 0;
        while (m_busy && k < 40) begin
            tick();
            k++;
        end

        // ---- reset asserted while waiting for a boundary ----
        write_rule(7, 1'b1, 33, 'hE7);
        commit_and_wait("pre_rst_done", NR + 6);
        chk("pre_rst_lane33", ovr_mask[33], 1'b1);
        mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0;
        tick();                                   // open a frame
        mon_tvalid = 1'b0;
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        repeat (NR + 3) tick();
        chk("rst_in_wait_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();                            // asynchronous clear
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
            chk("rst_no_done", commit_done, 1'b0);
        end
        rst_n = 1'b1;
        commit_and_wait("post_rst_done", NR + 6);
        chk("post_rst_mask", ovr_mask, 64'h0);
        chk("post_rst_gen", active_gen, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
